// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Produces one result bit per cycle; busy_o stalls the front of the pipeline.
module muldiv_unit #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic [1:0]        op_i,
  input  logic [N_BITS-1:0] rs_i,
  input  logic [N_BITS-1:0] rt_i,
  input  logic              flush_i,
  input  logic              hi_we_i,
  input  logic              lo_we_i,
  input  logic [N_BITS-1:0] wdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] hi_o,
  output logic [N_BITS-1:0] lo_o
);
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t              state, state_next;
  logic [2*N_BITS-1:0] acc, acc_next;
  logic [N_BITS-1:0]   m;
  logic [CW-1:0]       count;
  logic                is_div, neg_res, neg_rem, div_zero;
  logic                busy_q, done_q;
  logic [N_BITS-1:0]   hi_q, lo_q;

  logic              rs_neg, rt_neg;
  logic [N_BITS-1:0] rs_abs, rt_abs;
  logic [N_BITS:0]   mul_sum, div_shift, div_diff;
  logic [2*N_BITS-1:0] prod_fix;
  logic [N_BITS-1:0] quo_fix, rem_fix;

  assign rs_neg = !op_i[0] && rs_i[N_BITS-1];
  assign rt_neg = !op_i[0] && rt_i[N_BITS-1];
  assign rs_abs = rs_neg ? -rs_i : rs_i;
  assign rt_abs = rt_neg ? -rt_i : rt_i;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_i && !flush_i) state_next = CALC;
      CALC:    if (flush_i) state_next = IDLE;
               else if (count == LAST) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc holds {upper product, multiplier} for MULT and {remainder, quotient} for DIV
  always_comb begin
    mul_sum   = {1'b0, acc[2*N_BITS-1:N_BITS]} + (acc[0] ? {1'b0, m} : '0);
    div_shift = acc[2*N_BITS-1:N_BITS-1];
    div_diff  = div_shift - {1'b0, m};
    if (!is_div)
      acc_next = {mul_sum, acc[N_BITS-1:1]};
    else if (!div_diff[N_BITS])
      acc_next = {div_diff[N_BITS-1:0], acc[N_BITS-2:0], 1'b1};
    else
      acc_next = {div_shift[N_BITS-1:0], acc[N_BITS-2:0], 1'b0};
    prod_fix = neg_res ? -acc : acc;
    quo_fix  = div_zero ? '1 : (neg_res ? -acc[N_BITS-1:0] : acc[N_BITS-1:0]);
    rem_fix  = neg_rem ? -acc[2*N_BITS-1:N_BITS] : acc[2*N_BITS-1:N_BITS];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      acc      <= '0;
      m        <= '0;
      count    <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= 1'b0;
      case (state)
        IDLE: if (!flush_i) begin
          if (start_i) begin
            is_div   <= op_i[1];
            neg_res  <= rs_neg ^ rt_neg;
            neg_rem  <= rs_neg;
            div_zero <= op_i[1] && (rt_i == '0);
            count    <= '0;
            m        <= op_i[1] ? rt_abs : rs_abs;
            acc      <= {{N_BITS{1'b0}}, (op_i[1] ? rs_abs : rt_abs)};
          end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        CALC: if (!flush_i) begin
          acc   <= acc_next;
          count <= count + 1'b1;
        end
        FIX: if (!flush_i) begin
          done_q <= 1'b1;
          if (is_div) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            {hi_q, lo_q} <= prod_fix;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected {HI,LO} queued at issue, checked on done_o.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start_i, flush_i, hi_we_i, lo_we_i;
  logic [1:0]  op_i;
  logic [31:0] rs_i, rt_i, wdata_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] sb[$];

  muldiv_unit #(.N_BITS(32)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .flush_i(flush_i),
    .hi_we_i(hi_we_i), .lo_we_i(lo_we_i), .wdata_i(wdata_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every done_o pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && done_o) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got hilo %h expected no done", {hi_o, lo_o});
      end else begin
        chk("result", {hi_o, lo_o}, sb.pop_front());
      end
    end
  end

  // mode 0: plain; 1: MTHI/MTLO with start; 2: start+MT writes mid-operation
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input int mode);
    logic [63:0] prev;
    int n;
    logic busy_ok;
    @(negedge clk);
    prev = {hi_o, lo_o};
    start_i = 1'b1; op_i = op; rs_i = a; rt_i = b;
    if (mode == 1) begin
      hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hDEAD_BEEF;
    end
    sb.push_back({ehi, elo});
    @(posedge clk); #1;
    start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("busy_at_edge0", {63'd0, busy_o}, 64'd1);
    if (mode == 1) chk("mt_with_start_dropped", {hi_o, lo_o}, prev);
    n = 0;
    busy_ok = 1'b1;
    while (!done_o && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done_o && !busy_o) busy_ok = 1'b0;
      if (mode == 2 && n == 5) begin
        start_i = 1'b1; op_i = 2'b01; rs_i = 32'h1111_1111; rt_i = 32'h2;
        hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h5555_AAAA;
      end else if (mode == 2 && n == 6) begin
        start_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        chk("mt_while_busy_dropped", {hi_o, lo_o}, prev);
      end
    end
    chk("latency", 64'(n), 64'd33);
    chk("busy_held", {63'd0, busy_ok}, 64'd1);
    chk("busy_after_done", {63'd0, busy_o}, 64'd0);
  endtask

  initial begin
    logic [31:0] hi_before;
    logic saw_done;
    reset = 1'b1; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
    op_i = 2'b00; rs_i = '0; rt_i = '0; wdata_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {hi_o, lo_o}, 64'd0);
    chk("reset_flags", {62'd0, busy_o, done_o}, 64'd0);
    reset = 1'b0;

    // MTHI+MTLO together
    @(negedge clk); hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'h0000_CAFE;
    @(posedge clk); #1; hi_we_i = 1'b0; lo_we_i = 1'b0;
    chk("mthi_mtlo", {hi_o, lo_o}, 64'h0000_CAFE_0000_CAFE);

    issue(2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 0);
    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1);
    issue(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 2);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0);
    issue(2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 0);
    issue(2'b10, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 0);
    issue(2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 0);
    issue(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 0);
    issue(2'b00, 32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

    // MTLO, then a flushed MULTU leaves HI/LO untouched
    @(negedge clk); lo_we_i = 1'b1; wdata_i = 32'h0000_1234;
    @(posedge clk); #1; lo_we_i = 1'b0;
    chk("mtlo", {32'd0, lo_o}, 64'h1234);
    hi_before = hi_o;
    @(negedge clk); start_i = 1'b1; op_i = 2'b01; rs_i = 32'd5; rt_i = 32'd6;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush_i = 1'b1;
    @(posedge clk); #1; flush_i = 1'b0;
    @(posedge clk); #1;
    chk("busy_after_flush", {63'd0, busy_o}, 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o) saw_done = 1'b1;
    end
    chk("no_done_after_flush", {63'd0, saw_done}, 64'd0);
    chk("hilo_after_flush", {hi_o, lo_o}, {hi_before, 32'h0000_1234});

    // flush with start and MTHI in IDLE: nothing happens
    @(negedge clk); start_i = 1'b1; flush_i = 1'b1; hi_we_i = 1'b1; wdata_i = 32'h7777_7777;
    @(posedge clk); #1; start_i = 1'b0; flush_i = 1'b0; hi_we_i = 1'b0;
    chk("flush_beats_start", {63'd0, busy_o}, 64'd0);
    chk("flush_drops_mthi", {hi_o, lo_o}, {hi_before, 32'h0000_1234});

    // reset at edge 20 of a DIVU discards it
    @(negedge clk); start_i = 1'b1; op_i = 2'b11; rs_i = 32'd100; rt_i = 32'd7;
    @(posedge clk); #1; start_i = 1'b0;
    repeat (19) @(posedge clk);
    #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    chk("reset_mid_op_hilo", {hi_o, lo_o}, 64'd0);
    chk("reset_mid_op_flags", {62'd0, busy_o, done_o}, 64'd0);
    issue(2'b01, 32'd5, 32'd6, 32'h0, 32'h0000_001E, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
